// File: rtl/freq_meter_if.sv
// Control and result signals of the gated frequency meter.
// The master side drives the enable, the measured signal and the gate select; the slave side returns results.
interface freq_meter_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic             en;
  logic             sig_in;
  logic [1:0]       gate_sel;
  logic [CNT_W-1:0] freq;
  logic             freq_valid;
  logic             overflow;
  logic             busy;

  modport master (
    output en, sig_in, gate_sel,
    input  freq, freq_valid, overflow, busy
  );

  modport slave (
    input  en, sig_in, gate_sel,
    output freq, freq_valid, overflow, busy
  );
endinterface

// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a gate window and reports Hz.
// Optional macro FREQ_GATE_SEL_EN enables gate_sel ranges (1 s / 100 ms / 10 ms / 1 ms with x1..x1000 scaling).
module freq_meter #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  freq_meter_if.slave bus
);

  localparam int unsigned TMR_W  = $clog2(CLK_HZ + 1);
  localparam int unsigned PROD_W = CNT_W + 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   start_c;
  logic   last_c;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_prev_q;
  logic                   edge_c;

  logic [CNT_W-1:0] edge_cnt_q;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] gate_len_q;
  logic [TMR_W-1:0] gate_len_c;
  logic [CNT_W-1:0] result_c;
  logic             ovf_c;

  // Synchronizer chain plus previous-sample register for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      sig_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
      sig_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~sig_prev_q;

`ifdef FREQ_GATE_SEL_EN
  logic [9:0]        scale_c;
  logic [9:0]        scale_q;
  logic [PROD_W-1:0] prod_c;

  always_comb begin
    gate_len_c = TMR_W'(CLK_HZ);
    scale_c    = 10'd1;
    case (bus.gate_sel)
      2'd1: begin gate_len_c = TMR_W'(CLK_HZ / 10);   scale_c = 10'd10;   end
      2'd2: begin gate_len_c = TMR_W'(CLK_HZ / 100);  scale_c = 10'd100;  end
      2'd3: begin gate_len_c = TMR_W'(CLK_HZ / 1000); scale_c = 10'd1000; end
      default: ;
    endcase
  end

  // Scale captured with the gate length so a mid-gate gate_sel change cannot skew this window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scale_q <= 10'd1;
    end else if (start_c) begin
      scale_q <= scale_c;
    end
  end

  // Product is wide enough for edge_cnt*1000, so the range check never wraps
  assign prod_c   = PROD_W'(edge_cnt_q) * PROD_W'(scale_q);
  assign ovf_c    = (edge_cnt_q == CNT_MAX) || (prod_c > PROD_W'(CNT_MAX));
  assign result_c = ovf_c ? CNT_MAX : prod_c[CNT_W-1:0];
`else
  logic unused_gate_sel;

  assign unused_gate_sel = ^bus.gate_sel;
  assign gate_len_c      = TMR_W'(CLK_HZ);
  assign ovf_c           = (edge_cnt_q == CNT_MAX);
  assign result_c        = edge_cnt_q;
`endif

  assign last_c = (timer_q == gate_len_q - TMR_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start_c marks the cycle a new window is armed
  always_comb begin
    state_d = state_q;
    start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = GATE;
          start_c = 1'b1;
        end
      end
      GATE: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (last_c) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        if (bus.en) begin
          state_d = GATE;
          start_c = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate timer and saturating edge counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      timer_q    <= '0;
      gate_len_q <= TMR_W'(CLK_HZ);
    end else if (start_c) begin
      edge_cnt_q <= '0;
      timer_q    <= '0;
      gate_len_q <= gate_len_c;
    end else if (state_q == GATE) begin
      timer_q <= timer_q + TMR_W'(1);
      if (edge_c && (edge_cnt_q != CNT_MAX)) begin
        edge_cnt_q <= edge_cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered result outputs; freq/overflow hold across aborted windows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.freq       <= '0;
      bus.freq_valid <= 1'b0;
      bus.overflow   <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.busy       <= (state_d == GATE);
      bus.freq_valid <= (state_q == LATCH);
      if (state_q == LATCH) begin
        bus.freq     <= result_c;
        bus.overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a 16-bit and a 6-bit instance share stimulus with CLK_HZ=1000.
// Define FREQ_GATE_SEL_EN on both RTL and bench to include the gate-select steps.
module tb_freq_meter;

  localparam int unsigned CLK_HZ = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        sig;
  logic [1:0]  gate_sel;
  int unsigned half = 5;
  int          n_chk = 0;
  int          n_fail = 0;
  int          vcnt = 0;

  freq_meter_if #(.CNT_W(16)) bus16 ();
  freq_meter_if #(.CNT_W(6))  bus6 ();

  assign bus16.en       = en;
  assign bus16.sig_in   = sig;
  assign bus16.gate_sel = gate_sel;
  assign bus6.en        = en;
  assign bus6.sig_in    = sig;
  assign bus6.gate_sel  = gate_sel;

  freq_meter #(.CLK_HZ(CLK_HZ), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  freq_meter #(.CLK_HZ(CLK_HZ), .CNT_W(6), .SYNC_STAGES(2)) dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6.slave)
  );

  always #5 clk = ~clk;

  // Square wave with 'half' cycles high and 'half' low; half==0 holds the input low
  initial begin
    sig = 1'b0;
    forever begin
      if (half == 0) begin
        sig = 1'b0;
        @(negedge clk);
      end else begin
        sig = 1'b1;
        repeat (half) @(negedge clk);
        sig = 1'b0;
        repeat (half) @(negedge clk);
      end
    end
  end

  always @(negedge clk) begin
    if (bus16.freq_valid === 1'b1) vcnt = vcnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the next strobe (bounded); n returns the number of cycles waited
  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus16.freq_valid !== 1'b1 && n < 3000);
    chk({tag, "_strobe"}, 64'(bus16.freq_valid), 64'd1);
  endtask

  initial begin
    int n;
    int v0;
    rst      = 1'b0;
    en       = 1'b0;
    gate_sel = 2'd0;
    cycles(5);
    chk("rst_freq",  64'(bus16.freq),       64'd0);
    chk("rst_valid", 64'(bus16.freq_valid), 64'd0);
    chk("rst_ovf",   64'(bus16.overflow),   64'd0);
    chk("rst_busy",  64'(bus16.busy),       64'd0);

    rst = 1'b1;
    cycles(20);
    chk("idle_busy",    64'(bus16.busy), 64'd0);
    chk("idle_novalid", 64'(vcnt),       64'd0);

    // Continuous measurement, period 10 -> 100 Hz; 6-bit instance saturates
    en = 1'b1;
    cycles(1);
    chk("gate_busy", 64'(bus16.busy), 64'd1);
    wait_valid("w1", n);
    chk("w1_freq",  64'(bus16.freq),     64'd100);
    chk("w1_ovf",   64'(bus16.overflow), 64'd0);
    chk("w1_freq6", 64'(bus6.freq),      64'd63);
    chk("w1_ovf6",  64'(bus6.overflow),  64'd1);
    cycles(1);
    chk("w1_pulse_len", 64'(bus16.freq_valid), 64'd0);
    wait_valid("w2", n);
    chk("w2_period", 64'(n),          64'd1000);
    chk("w2_freq",   64'(bus16.freq), 64'd100);

    // Abort 500 cycles into a gate
    cycles(500);
    en = 1'b0;
    cycles(1);
    chk("abort_busy", 64'(bus16.busy), 64'd0);
    v0 = vcnt;
    cycles(1200);
    chk("abort_novalid", 64'(vcnt - v0),    64'd0);
    chk("abort_hold",    64'(bus16.freq),   64'd100);
    chk("abort_hold6",   64'(bus6.freq),    64'd63);

    // Asynchronous reset mid-gate while the input toggles
    en = 1'b1;
    wait_valid("w3", n);
    chk("w3_freq", 64'(bus16.freq), 64'd100);
    cycles(300);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_freq",  64'(bus16.freq),     64'd0);
    chk("mid_rst_busy",  64'(bus16.busy),     64'd0);
    chk("mid_rst_freq6", 64'(bus6.freq),      64'd0);
    chk("mid_rst_ovf6",  64'(bus6.overflow),  64'd0);
    en = 1'b0;
    cycles(3);
    rst = 1'b1;
    v0 = vcnt;
    cycles(50);
    chk("post_rst_busy",    64'(bus16.busy), 64'd0);
    chk("post_rst_novalid", 64'(vcnt - v0),  64'd0);

    // Period 4 -> 250 edges; 6-bit instance saturates at 63
    half = 2;
    cycles(20);
    en = 1'b1;
    wait_valid("w5a", n);
    chk("w5a_freq",  64'(bus16.freq),     64'd250);
    chk("w5a_ovf",   64'(bus16.overflow), 64'd0);
    chk("w5a_freq6", 64'(bus6.freq),      64'd63);
    chk("w5a_ovf6",  64'(bus6.overflow),  64'd1);

    // Period 20 -> 50 edges, fits in 6 bits so overflow clears
    half = 10;
    wait_valid("w5b", n);
    wait_valid("w5c", n);
    chk("w5c_freq",  64'(bus16.freq),     64'd50);
    chk("w5c_freq6", 64'(bus6.freq),      64'd50);
    chk("w5c_ovf6",  64'(bus6.overflow),  64'd0);

    // Constant-low input still produces a strobe with freq 0
    half = 0;
    wait_valid("w6a", n);
    wait_valid("w6b", n);
    chk("w6b_freq",  64'(bus16.freq),     64'd0);
    chk("w6b_ovf",   64'(bus16.overflow), 64'd0);
    chk("w6b_freq6", 64'(bus6.freq),      64'd0);

`ifdef FREQ_GATE_SEL_EN
    // 100-cycle gate x10; then a mid-gate switch to the 1-cycle gate
    half = 5;
    wait_valid("g0a", n);
    gate_sel = 2'd1;
    wait_valid("g0b", n);
    wait_valid("g1", n);
    chk("g1_period", 64'(n),              64'd101);
    chk("g1_freq",   64'(bus16.freq),     64'd100);
    chk("g1_freq6",  64'(bus6.freq),      64'd63);
    chk("g1_ovf6",   64'(bus6.overflow),  64'd1);
    cycles(50);
    gate_sel = 2'd3;
    wait_valid("g2", n);
    chk("g2_period", 64'(n),          64'd51);
    chk("g2_freq",   64'(bus16.freq), 64'd100);
    wait_valid("g3", n);
    chk("g3_period", 64'(n), 64'd2);
`endif

    en = 1'b0;
    cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
